// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: sequences one divide at a time through a multi-cycle
// divider and turns the result into a single-cycle register writeback.
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   ctrl_DIV, operandA/B, rd_in  divide request from execute (1-cycle pulse)
//   stall                        freeze upstream while the divider is busy
//   div_dividend/divisor/start   operands and init pulse to the divider
//   div_quotient/resultRDY/exception  divider results
//   wb_en, wb_rd, wb_data        writeback request (wb_en qualifies rd/data)
//   timeout_err                  sticky watchdog flag, cleared only by reset
module div_issue_ctrl #(
  parameter int unsigned TIMEOUT    = 40,
  parameter int unsigned STATUS_REG = 30,
  parameter int unsigned DIV_STATUS = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_DIV,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic [4:0]  rd_in,
  output logic        stall,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_start,
  input  logic [31:0] div_quotient,
  input  logic        div_resultRDY,
  input  logic        div_exception,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        timeout_err
);

  localparam logic [5:0]  CNT_LAST = 6'(TIMEOUT - 1);
  localparam logic [4:0]  EXC_RD   = 5'(STATUS_REG);
  localparam logic [31:0] EXC_DATA = 32'(DIV_STATUS);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    WB
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  rd_q, rd_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        wben_q, wben_d;
  logic [4:0]  wbrd_q, wbrd_d;
  logic [31:0] wbdat_q, wbdat_d;
  logic        terr_q, terr_d;
  logic        accept;

  // New requests are only taken when no division is in flight; WB counts
  // as free so back-to-back divides need no idle bubble.
  assign accept = ctrl_DIV & ((state_q == IDLE) | (state_q == WB));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    wben_d  = 1'b0;
    wbrd_d  = wbrd_q;
    wbdat_d = wbdat_q;
    terr_d  = terr_q;
    if (accept) begin
      a_d  = operandA;
      b_d  = operandB;
      rd_d = rd_in;
      if (operandB == 32'd0) begin
        // Divide-by-zero never reaches the divider.
        state_d = WB;
        wben_d  = 1'b1;
        wbrd_d  = EXC_RD;
        wbdat_d = EXC_DATA;
      end else begin
        state_d = START;
      end
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        START: begin
          state_d = WAIT;
          cnt_d   = 6'd0;
        end
        WAIT: begin
          if (div_resultRDY) begin
            state_d = WB;
            if (div_exception) begin
              wben_d  = 1'b1;
              wbrd_d  = EXC_RD;
              wbdat_d = EXC_DATA;
            end else begin
              wben_d  = (rd_q != 5'd0);
              wbrd_d  = rd_q;
              wbdat_d = div_quotient;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_d = WB;
            wben_d  = 1'b1;
            wbrd_d  = EXC_RD;
            wbdat_d = EXC_DATA;
            terr_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        WB: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      wben_q  <= 1'b0;
      wbrd_q  <= '0;
      wbdat_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      wben_q  <= wben_d;
      wbrd_q  <= wbrd_d;
      wbdat_q <= wbdat_d;
      terr_q  <= terr_d;
    end
  end

  // Gated by reset so stall drops the instant reset asserts.
  assign stall = ~reset &
                 ((state_q == START) | (state_q == WAIT) | accept);
  assign div_start    = (state_q == START);
  assign div_dividend = a_q;
  assign div_divisor  = b_q;
  assign wb_en        = wben_q;
  assign wb_rd        = wbrd_q;
  assign wb_data      = wbdat_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl: a driver issues divides against a
// latency-programmable divider model; a monitor checks every cycle.
module tb_div_issue_ctrl;

  localparam int TO  = 40;
  localparam int BIG = 1 << 30;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] operandA = '0;
  logic [31:0] operandB = '0;
  logic [4:0]  rd_in = '0;
  logic        stall;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_start;
  logic [31:0] div_quotient;
  logic        div_resultRDY;
  logic        div_exception;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        timeout_err;

  div_issue_ctrl #(
    .TIMEOUT(TO),
    .STATUS_REG(30),
    .DIV_STATUS(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ctrl_DIV(ctrl_DIV),
    .operandA(operandA),
    .operandB(operandB),
    .rd_in(rd_in),
    .stall(stall),
    .div_dividend(div_dividend),
    .div_divisor(div_divisor),
    .div_start(div_start),
    .div_quotient(div_quotient),
    .div_resultRDY(div_resultRDY),
    .div_exception(div_exception),
    .wb_en(wb_en),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Divider model: result ready L cycles after the start cycle; L=0 never.
  int          dv_lat = 1;
  bit          dv_exc = 1'b0;
  int          dv_cnt = 0;
  logic [31:0] dv_q = '0;
  always @(posedge clock) begin
    if (div_start) begin
      dv_cnt <= dv_lat;
      dv_q   <= (div_divisor != 0) ? div_dividend / div_divisor
                                   : 32'hdead_beef;
    end else if (dv_cnt > 0) begin
      dv_cnt <= dv_cnt - 1;
    end
  end
  assign div_resultRDY = (dv_cnt == 1);
  assign div_quotient  = dv_exc ? 32'hbad0_0bad : dv_q;
  assign div_exception = div_resultRDY & dv_exc;

  typedef struct {
    int          c;
    logic [4:0]  rd;
    logic [31:0] d;
  } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int req_c = 0;
  int wb_c = 0;
  int start_c = -1;
  int terr_from = BIG;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, expv);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      exp_t e;
      chk("stall", stall, (cyc >= req_c) && (cyc < wb_c));
      chk("div_start", div_start, cyc == start_c);
      chk("timeout_err", timeout_err, cyc >= terr_from);
      if (wb_en) begin
        if (sbq.size() == 0) begin
          chk("wb_en_spurious", wb_en, 0);
        end else begin
          e = sbq.pop_front();
          chk("wb_cycle", cyc, e.c);
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_data", wb_data, e.d);
        end
      end else if (sbq.size() > 0 && sbq[0].c <= cyc) begin
        chk("wb_missing", wb_en, 1);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic push(input int c, input logic [4:0] rd,
                      input logic [31:0] d);
    exp_t e;
    e.c  = c;
    e.rd = rd;
    e.d  = d;
    sbq.push_back(e);
  endtask

  // gap 0 issues in the previous writeback cycle (back-to-back).
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int lat,
                       input bit exc, input int gap);
    int tgt;
    tgt = wb_c + gap;
    while (cyc < tgt) begin
      @(posedge clock);
      #1;
    end
    operandA = a;
    operandB = b;
    rd_in    = rd;
    ctrl_DIV = 1'b1;
    dv_lat   = lat;
    dv_exc   = exc;
    req_c    = cyc;
    if (b == 0) begin
      start_c = -1;
      wb_c    = cyc + 1;
      push(wb_c, 5'd30, 32'd5);
    end else begin
      start_c = cyc + 1;
      if (lat >= 1 && lat <= TO) begin
        wb_c = cyc + 2 + lat;
        if (exc) push(wb_c, 5'd30, 32'd5);
        else if (rd != 0) push(wb_c, rd, a / b);
      end else begin
        wb_c = cyc + 2 + TO;
        push(wb_c, 5'd30, 32'd5);
        if (terr_from == BIG) terr_from = wb_c;
      end
    end
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    operandA = $urandom;
    operandB = $urandom;
    rd_in    = 5'($urandom);
  endtask

  // Stray request while busy, k cycles after the accepted one.
  task automatic ignore_at(input int k);
    while (cyc < req_c + k) begin
      @(posedge clock);
      #1;
    end
    operandA = $urandom;
    operandB = $urandom_range(0, 3);
    rd_in    = 5'($urandom);
    ctrl_DIV = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_div_start"}, div_start, 0);
    chk({tag, "_wb_en"}, wb_en, 0);
    chk({tag, "_wb_rd"}, wb_rd, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_dividend"}, div_dividend, 0);
    chk({tag, "_divisor"}, div_divisor, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    int lat;
    int span;
    logic [31:0] b;
    repeat (3) @(posedge clock);
    #1;
    check_zero("rst");
    reset = 1'b0;
    @(posedge clock);
    #1;
    issue(32'd6480321, 32'd746, 5'd7, 33, 1'b0, 1);
    issue(32'd50, 32'd0, 5'd9, 1, 1'b0, 2);
    issue(32'd32, 32'd8, 5'd4, 6, 1'b0, 2);
    issue(32'd500, 32'd3, 5'd11, 10, 1'b0, 0);
    issue(32'd100, 32'd7, 5'd3, 20, 1'b0, 0);
    ignore_at(1);
    ignore_at(5);
    ignore_at(15);
    issue(32'd99, 32'd9, 5'd0, 4, 1'b0, 1);
    issue(32'd99, 32'd9, 5'd0, 4, 1'b1, 0);
    issue(32'd7, 32'd0, 5'd6, 1, 1'b0, 0);
    issue(32'hffff_ffff, 32'd1, 5'd31, 40, 1'b0, 0);
    issue(32'd81, 32'd9, 5'd12, 41, 1'b0, 0);
    issue(32'd15, 32'd4, 5'd8, 0, 1'b0, 0);
    issue(32'd77, 32'd7, 5'd13, 2, 1'b0, 3);
    // Reset 10 cycles into WAIT abandons the division.
    issue(32'd6480321, 32'd746, 5'd7, 33, 1'b0, 1);
    while (cyc < req_c + 12) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    #1;
    check_zero("midrst");
    sbq.delete();
    req_c     = 0;
    wb_c      = 0;
    start_c   = -1;
    terr_from = BIG;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    issue(32'd15, 32'd4, 5'd2, 5, 1'b0, 0);
    for (int i = 0; i < 40; i++) begin
      b = ($urandom % 8 == 0) ? 32'd0 :
          (($urandom % 2 == 0) ? $urandom : 32'($urandom_range(1, 50)));
      case ($urandom % 10)
        0: lat = 0;
        1: lat = $urandom_range(41, 45);
        default: lat = $urandom_range(1, 40);
      endcase
      issue($urandom, b, 5'($urandom), lat, ($urandom % 8) == 0,
            $urandom % 3);
      span = wb_c - req_c;
      if (span >= 3 && ($urandom % 3) == 0)
        ignore_at($urandom_range(1, span - 1));
    end
    while (cyc < wb_c + 3) begin
      @(posedge clock);
      #1;
    end
    chk("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

endmodule
